// File: rtl/wb_pkg.sv
// Shared encodings for the MIPS write-back stage.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic {
    MEM_SZ_BYTE = 1'b0,
    MEM_SZ_WORD = 1'b1
  } mem_sz_e;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: byte-lane select with sign/zero extension, or full-word pass-through.
module wb_load_align
  import wb_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_size_i,
  input  logic              mem_signed_i,
  input  logic [OFF_W-1:0]  mem_off_i,
  output logic [DATA_W-1:0] aligned_o
);

  logic [DATA_W-1:0] shifted;
  logic [7:0]        byte_v;
  logic              ext_bit;

  always_comb begin
    shifted = mem_data_i >> {mem_off_i, 3'b000};
    byte_v  = shifted[7:0];
    ext_bit = byte_v[7] & mem_signed_i;
    if (mem_sz_e'(mem_size_i) == MEM_SZ_WORD) begin
      aligned_o = mem_data_i;
    end else begin
      aligned_o = {{(DATA_W-8){ext_bit}}, byte_v};
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: source mux, registered register-file/forwarding port, saturating retire counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int REG_ADDR_W = 3,
  parameter  int CNT_W      = 16,
  localparam int OFF_W      = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [1:0]            wb_sel,
  input  logic                  mem_size,
  input  logic                  mem_signed,
  input  logic [OFF_W-1:0]      mem_off,
  input  logic [DATA_W-1:0]     rd_data_alu,
  input  logic [DATA_W-1:0]     rd_data_mem,
  input  logic [DATA_W-1:0]     link_addr,
  input  logic [DATA_W-1:0]     imm_data,
  input  logic                  cnt_clear,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     result;
  logic                  wr_qual;

  logic                  we_q,    we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .mem_data_i   (rd_data_mem),
    .mem_size_i   (mem_size),
    .mem_signed_i (mem_signed),
    .mem_off_i    (mem_off),
    .aligned_o    (load_data)
  );

  always_comb begin
    result = rd_data_alu;
    case (wb_sel_e'(wb_sel))
      WB_SEL_ALU:  result = rd_data_alu;
      WB_SEL_MEM:  result = load_data;
      WB_SEL_LINK: result = link_addr;
      WB_SEL_IMM:  result = imm_data;
      default:     result = rd_data_alu;
    endcase
  end

  assign wr_qual = in_valid & reg_write & (rd_addr != '0);

  // Flush only kills the write qualifier; address/data hold so the bus stays quiet.
  always_comb begin
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (flush) begin
      we_d = 1'b0;
    end else if (!stall) begin
      we_d    = wr_qual;
      waddr_d = rd_addr;
      wdata_d = result;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (in_valid && !stall && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign fwd_valid  = we_q;
  assign fwd_addr   = waddr_q;
  assign fwd_data   = wdata_q;
  assign retire_cnt = cnt_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the 16-bit MIPS pipeline, replacing the purely combinational ALU/memory write-data mux. It registers the MEM/WB bundle and selects among four result sources: ALU, memory load, link address, and immediate. Memory loads get byte-lane alignment with sign or zero extension. The stage drives the register-file write port, mirrors that port as a forwarding source for the decode/execute bypass, and keeps a saturating retired-instruction counter.

## Interface
- `DATA_W`, 16: datapath width; must be a multiple of 8, with `DATA_W >= 16`.
- `REG_ADDR_W`, 3: register-file address width.
- `CNT_W`, 16: width of the retired-instruction counter.
- `OFF_W`, derived as `$clog2(DATA_W/8)`: byte-offset width. Not user-overridable.

Ports (name, direction, width, meaning):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hold the stage register.
- `flush` input 1: kill the incoming bundle.
- `in_valid` input 1: incoming bundle is a real instruction.
- `reg_write` input 1: instruction writes a register.
- `rd_addr` input `REG_ADDR_W`: destination register.
- `wb_sel` input 2: source select; 0=ALU, 1=MEM, 2=LINK, 3=IMM.
- `mem_size` input 1: 0=byte, 1=full word.
- `mem_signed` input 1: 1 = sign-extend a byte load.
- `mem_off` input `OFF_W`: byte offset within the word.
- `rd_data_alu`, `rd_data_mem`, `link_addr`, `imm_data` input `DATA_W` each: source operands.
- `cnt_clear` input 1: clear the retire counter.
- `rf_we` output 1: register-file write enable.
- `rf_waddr` output `REG_ADDR_W`: register-file write address.
- `rf_wdata` output `DATA_W`: register-file write data.
- `fwd_valid` output 1: forwarding source valid.
- `fwd_addr` output `REG_ADDR_W`: forwarding address.
- `fwd_data` output `DATA_W`: forwarding data.
- `retire_cnt` output `CNT_W`: number of valid bundles captured.

## Operation
- Source mux is evaluated combinationally on the inputs. The result, `rd_addr`, and a write qualifier are captured into the stage register, so all outputs are registered.
- Load alignment when `wb_sel`=MEM:
  - `mem_size`=1: pass `rd_data_mem` through; `mem_off` is ignored.
  - `mem_size`=0: select byte `rd_data_mem[8*mem_off +: 8]`. Upper `DATA_W-8` bits are copies of bit 7 when `mem_signed`=1, else zero.
- `mem_size`, `mem_signed`, and `mem_off` are ignored for every other `wb_sel` value.
- Write qualifier: `in_valid & reg_write & (rd_addr != 0)`. Register 0 is never written.
- Stage register update priority: `rst` > `flush` > `stall` > load.
  - `flush`: qualifier cleared; data and address registers hold.
  - `stall`: all stage registers hold.
  - Otherwise: the new bundle is captured.
- `rf_we` equals the registered qualifier. `rf_waddr` and `rf_wdata` are the registered address and data.
- The forwarding port (`fwd_valid`, `fwd_addr`, `fwd_data`) carries identical values to `rf_we`, `rf_waddr`, `rf_wdata`. It is a separate port so consumers never tap the register-file bus.
- Retire counter, priority `rst` > `cnt_clear` > increment:
  - Increments when `in_valid & !stall & !flush`, whether or not the instruction writes a register.
  - Saturates at all-ones; never wraps.
  - `cnt_clear` in the same cycle as an increment leaves the counter at 0; the increment is lost.

## Timing
- Latency: 1 cycle from the input bundle to `rf_*` and `fwd_*`.
- Reset values: `rf_we`=0, `fwd_valid`=0, `rf_waddr`/`fwd_addr`=0, `rf_wdata`/`fwd_data`=0, `retire_cnt`=0.
- `rst` asserted mid-stall or mid-flush overrides both; outputs return to reset values on the next edge.
- `stall` held for N cycles: `rf_we` stays at its held value for those N cycles. The register file must tolerate a repeated identical write; this is an accepted idempotent rewrite.
- `flush` and `stall` together: `flush` wins, and `rf_we`=0 on the next cycle.
- No combinational path from any input to any output.

## Structure
- `wb_pkg` holds:
  - `wb_sel` encodings: `WB_SEL_ALU`=0, `WB_SEL_MEM`=1, `WB_SEL_LINK`=2, `WB_SEL_IMM`=3.
  - `mem_size` encodings: `MEM_SZ_BYTE`=0, `MEM_SZ_WORD`=1.
- One combinational sub-module, `wb_load_align`, parametrised on `DATA_W`: byte-lane select plus sign/zero extension.
- The top level `wb_stage` contains the source mux, the stage register, and the retire counter.

## Test plan
- Reset: hold `rst` for 2 cycles with arbitrary inputs. Require all outputs 0 and `retire_cnt`=0.
- Source select, `in_valid`=1, `reg_write`=1, `rd_addr`=3, with `rd_data_alu`=0x1234, `rd_data_mem`=0xBEEF, `link_addr`=0x0042, `imm_data`=0x7F00:
  - `wb_sel` 0..3 on consecutive cycles.
  - One cycle later each: `rf_wdata` = 0x1234, 0xBEEF, 0x0042, 0x7F00, with `rf_we`=1 and `fwd_data` matching.
- Byte loads, `rd_data_mem`=0x80F5, `mem_size`=0:
  - off=0, signed → 0xFFF5; off=0, unsigned → 0x00F5.
  - off=1, signed → 0xFF80; off=1, unsigned → 0x0080.
- R0 and flush/stall:
  - `rd_addr`=0 with `reg_write`=1 → `rf_we`=0, but `retire_cnt` increments.
  - `stall` for 3 cycles → `rf_*` held for 3 cycles.
  - `flush`+`stall` together → `rf_we`=0 next cycle and `retire_cnt` unchanged.
- Counter, with `CNT_W`=4:
  - 17 valid captures → `retire_cnt`=15 (saturated).
  - `cnt_clear` together with a valid capture → `retire_cnt`=0.
  - One more valid capture → 1.
